line_delay_ctrl: RTL
====================

Name: line_delay_ctrl

Overview:
- Single-clock controller that owns both ports of one true_dp_bram instance (port A write, port B read) and uses it as a one-line pixel delay.
- Accepts a raster pixel stream with a valid/ready handshake.
- Emits each pixel paired with the pixel at the same column on the previous line, forming the vertical tap pair for the 2D FIR window.
- Sits between the pixel input stage and the FIR column/tap logic. Several instances can be chained for taller kernels.

Parameters:
WIDTH, 8, pixel width; must match the BRAM WIDTH.
LINE_LEN, 1920, pixels per line; must be ≤ BRAM DEPTH (2000).
ADDR_W, 11, BRAM address width.
LCNT_W, 12, width of the line counter.

Ports:
clk  input  1  single clock; drives both BRAM clocks (clk_a, clk_b).
rst_n  input  1  asynchronous, active-low reset.
s_valid  input  1  input pixel valid.
s_ready  output  1  input pixel accepted this cycle when s_valid && s_ready.
s_data  input  WIDTH  input pixel.
s_sof  input  1  start of frame; qualified with an accepted beat.
m_valid  output  1  output pair valid.
m_ready  input  1  downstream ready.
m_cur  output  WIDTH  current-line pixel.
m_above  output  WIDTH  previous-line pixel at the same column.
m_col  output  ADDR_W  column of the output pair.
m_first  output  1  output belongs to line 0 of the frame.
line_cnt  output  LCNT_W  lines completed in the current frame; saturates at all-ones.
bram_we_a  output  1  BRAM port A write enable.
bram_addr_a  output  ADDR_W  BRAM port A address.
bram_din_a  output  WIDTH  BRAM port A write data.
bram_re_b  output  1  BRAM port B read enable.
bram_addr_b  output  ADDR_W  BRAM port B read address.
bram_dout_b  input  WIDTH  BRAM registered read data; 1-cycle latency; holds its value while re_b = 0.

Behaviour:
- Reset (asynchronous, rst_n = 0) clears: col = 0, line_cnt = 0, first = 1, m_valid = 0, m_cur = 0, m_col = 0, m_first = 0.
- BRAM contents are not cleared by reset; correctness never depends on them (see first-line masking).
- s_ready = !m_valid || m_ready. This is a single output stage with no skid buffer; the combinational path from m_ready to s_ready is intentional.
- On an accepted beat:
  - Issue we_a = 1, addr_a = col_eff, din_a = s_data.
  - In the same cycle issue re_b = 1, addr_b = col_eff.
  - The same-address read sees the old contents (read-first, because the write is a non-blocking register update), which is the previous line's pixel.
- col_eff = 0 if s_sof is asserted on the beat, else col.
- bram_we_a and bram_re_b are 0 on every cycle without an accepted beat. The address and data ports may hold stale values then.
- Output registers load one cycle after the accepted beat:
  - m_valid <= 1; m_cur <= s_data; m_col <= col_eff; m_first <= first_eff.
  - m_above is combinational: bram_dout_b, or 0 when m_first = 1.
  - bram_dout_b stays stable while m_valid && !m_ready, because no new read is issued while stalled.
- If there is no accept and m_ready = 1, m_valid <= 0.
- Latency: accepted beat to m_valid is 1 cycle. Throughput is 1 pair per cycle.
- Column counter:
  - After an accept, col <= col_eff + 1, wrapping to 0 when col_eff == LINE_LEN-1.
  - On a wrap: line_cnt += 1 (saturating) and first <= 0.
- s_sof on an accepted beat:
  - col_eff = 0, first_eff = 1.
  - line_cnt is cleared to 0 and first is set to 1 before the wrap logic is applied.
  - s_sof in the middle of a line therefore aborts that line and restarts the frame.
- s_sof without s_valid && s_ready is ignored.
- Reset mid-stream drops any in-flight pair (m_valid = 0). The first beat after reset is treated as line 0 even without s_sof.

Optional Feature:
- Macro: LINE_DELAY_BORDER_REPLICATE_EN.
- Defined: on line 0, m_above = m_cur (replicate top border).
- Undefined: on line 0, m_above = 0 (zero padding).
- Lines ≥ 1 behave identically in both builds.

Test Plan:
- LINE_LEN=4, feed pixels 1..8 continuously with s_sof on pixel 1 and m_ready = 1 → pairs (1,0)(2,0)(3,0)(4,0)(5,1)(6,2)(7,3)(8,4); m_first = 1 for the first 4 pairs; line_cnt = 2 after pixel 8; m_valid exactly 1 cycle after each accept.
- Same stream with m_ready held low for 3 cycles while pair (6,2) is presented → m_cur/m_above/m_col hold at 6/2/1; s_ready = 0; bram_we_a = bram_re_b = 0 during the stall; no pair lost or duplicated.
- Assert s_sof on the 3rd pixel of line 1 (value 0x55) → that pair has m_col = 0, m_first = 1, m_above = 0; line_cnt reads 0 afterwards.
- Assert rst_n low for 2 cycles mid-line 1 → m_valid = 0 immediately; the next pixel (0xAA, no s_sof) yields m_col = 0, m_first = 1, m_above = 0, despite stale BRAM data.
- Build with LINE_DELAY_BORDER_REPLICATE_EN and repeat scenario 1 → line-0 pairs (1,1)(2,2)(3,3)(4,4); line-1 pairs unchanged.
- Randomised s_valid and m_ready over 3 lines of LINE_LEN=4 → every output pair equals a reference model; line_cnt = 3 at the end.

Source files
------------

// File: rtl/line_delay_ctrl.sv
// One-line pixel delay controller driving both ports of an external true_dp_bram (A = write, B = read).
// Optional build macro LINE_DELAY_BORDER_REPLICATE_EN: replicate line 0 into m_above instead of zero padding.
module line_delay_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LINE_LEN = 1920,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned LCNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_cur,
  output logic [WIDTH-1:0]  m_above,
  output logic [ADDR_W-1:0] m_col,
  output logic              m_first,
  output logic [LCNT_W-1:0] line_cnt,
  output logic              bram_we_a,
  output logic [ADDR_W-1:0] bram_addr_a,
  output logic [WIDTH-1:0]  bram_din_a,
  output logic              bram_re_b,
  output logic [ADDR_W-1:0] bram_addr_b,
  input  logic [WIDTH-1:0]  bram_dout_b
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;

  logic [ADDR_W-1:0] col;
  logic              first;

  logic              accept_c;
  logic [ADDR_W-1:0] col_eff_c;
  logic              first_eff_c;
  logic [ADDR_W-1:0] col_nxt_c;
  logic [LCNT_W-1:0] line_cnt_nxt_c;
  logic              first_nxt_c;
  logic [LCNT_W-1:0] lcnt_base_c;

  // Single output stage: a new beat is taken whenever the stage is empty or draining.
  assign s_ready  = !m_valid || m_ready;
  assign accept_c = s_valid && s_ready;

  // Write and read the same column together; the read returns the previous line's pixel.
  assign bram_we_a   = accept_c;
  assign bram_addr_a = col_eff_c;
  assign bram_din_a  = s_data;
  assign bram_re_b   = accept_c;
  assign bram_addr_b = col_eff_c;

  // Column / line bookkeeping; s_sof restarts the frame before wrap handling.
  always_comb begin
    col_eff_c      = s_sof ? '0 : col;
    first_eff_c    = s_sof | first;
    lcnt_base_c    = s_sof ? '0 : line_cnt;
    col_nxt_c      = col_eff_c + ADDR_W'(1);
    line_cnt_nxt_c = lcnt_base_c;
    first_nxt_c    = first_eff_c;
    if (col_eff_c == LAST_COL) begin
      col_nxt_c   = '0;
      first_nxt_c = 1'b0;
      if (lcnt_base_c != LCNT_MAX) begin
        line_cnt_nxt_c = lcnt_base_c + LCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      line_cnt <= '0;
      first    <= 1'b1;
    end else if (accept_c) begin
      col      <= col_nxt_c;
      line_cnt <= line_cnt_nxt_c;
      first    <= first_nxt_c;
    end
  end

  // Output pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cur   <= '0;
      m_col   <= '0;
      m_first <= 1'b0;
    end else if (accept_c) begin
      m_valid <= 1'b1;
      m_cur   <= s_data;
      m_col   <= col_eff_c;
      m_first <= first_eff_c;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // BRAM contents are never trusted on line 0 of a frame.
`ifdef LINE_DELAY_BORDER_REPLICATE_EN
  assign m_above = m_first ? m_cur : bram_dout_b;
`else
  assign m_above = m_first ? '0 : bram_dout_b;
`endif

endmodule
